// File: rtl/alu_control_unit_param_if.sv
// Status/control bundle between the ALU sequencer (slave side) and its requester/datapath (master side).
interface alu_control_unit_param_if;
  logic       BEGIN;
  logic [1:0] op_code;
  logic [2:0] bits_of_Q;
  logic [2:0] bits_of_A;
  logic       sgn_bit_of_M;
  logic       m_is_zero;
  logic       load_a, load_q, load_m;
  logic       init_a0, init_qq;
  logic       load_a_adder, load_qp_adder, load_q_adder;
  logic       sel_am, sel_2m, sel_qp1, sel_qqp;
  logic       sum_or_dif;
  logic       rshift2, lshift, norm_shift, denorm_shift;
  logic       q_wr, q_val, qp_val;
  logic       push_a, push_q;
  logic       busy, div_by_zero, END;

  modport master (
    output BEGIN, op_code, bits_of_Q, bits_of_A, sgn_bit_of_M, m_is_zero,
    input  load_a, load_q, load_m, init_a0, init_qq,
           load_a_adder, load_qp_adder, load_q_adder,
           sel_am, sel_2m, sel_qp1, sel_qqp, sum_or_dif,
           rshift2, lshift, norm_shift, denorm_shift,
           q_wr, q_val, qp_val, push_a, push_q, busy, div_by_zero, END
  );

  modport slave (
    input  BEGIN, op_code, bits_of_Q, bits_of_A, sgn_bit_of_M, m_is_zero,
    output load_a, load_q, load_m, init_a0, init_qq,
           load_a_adder, load_qp_adder, load_q_adder,
           sel_am, sel_2m, sel_qp1, sel_qqp, sum_or_dif,
           rshift2, lshift, norm_shift, denorm_shift,
           q_wr, q_val, qp_val, push_a, push_q, busy, div_by_zero, END
  );
endinterface

// File: rtl/alu_control_unit_param.sv
// One-hot sequencer for add/sub, radix-4 Booth multiply and SRT-2 divide over WIDTH-bit operands.
// Optional divide-by-zero abort is enabled by defining ALU_DIV_BY_ZERO_DETECT_EN.
module alu_control_unit_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_control_unit_param_if.slave bus
);
  localparam int S_IDLE    = 0;
  localparam int S_LOADA   = 1;
  localparam int S_LOADQ   = 2;
  localparam int S_LOADM   = 3;
  localparam int S_ADD     = 4;
  localparam int S_RSHIFT2 = 5;
  localparam int S_PUSHA   = 6;
  localparam int S_PUSHQ   = 7;
  localparam int S_NORM    = 8;
  localparam int S_LSHIFT  = 9;
  localparam int S_CORR_A  = 10;
  localparam int S_CORR_QP = 11;
  localparam int S_FIX_Q   = 12;
  localparam int S_DENORM  = 13;
  localparam int S_DIVZ    = 14;
  localparam int NS        = 15;

  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [CNT_W-1:0] R_LAST  = CNT_W'(WIDTH / 2 - 1);
  localparam logic [CNT_W-1:0] S_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] S_DONE  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LZ_LAST = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [NS-1:0]    state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_r_q, cnt_r_d, cnt_s_q, cnt_s_d, lz_q, lz_d;
  logic [1:0]       digit_q, digit_d;  // {nonzero quotient digit, A sign} seen in the last LSHIFT
  logic             done_q, done_d;

  logic is_mul, is_div, booth_add, a_flag, a_neg, div_zero;

  assign is_mul    = (op_q == OP_MUL);
  assign is_div    = (op_q == OP_DIV);
  assign booth_add = !((bus.bits_of_Q == 3'b000) || (bus.bits_of_Q == 3'b111));
  assign a_flag    = !((bus.bits_of_A == 3'b000) || (bus.bits_of_A == 3'b111));
  assign a_neg     = bus.bits_of_A[2];

`ifdef ALU_DIV_BY_ZERO_DETECT_EN
  assign div_zero = bus.m_is_zero;
`else
  logic unused_m_is_zero;
  assign unused_m_is_zero = bus.m_is_zero;
  assign div_zero         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= {{(NS-1){1'b0}}, 1'b1};
      op_q    <= '0;
      cnt_r_q <= '0;
      cnt_s_q <= '0;
      lz_q    <= '0;
      digit_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_r_q <= cnt_r_d;
      cnt_s_q <= cnt_s_d;
      lz_q    <= lz_d;
      digit_q <= digit_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = '0;
    op_d    = op_q;
    cnt_r_d = cnt_r_q;
    cnt_s_d = cnt_s_q;
    lz_d    = lz_q;
    digit_d = digit_q;
    done_d  = 1'b0;
    case (1'b1)
      state_q[S_IDLE]: begin
        if (bus.BEGIN) begin
          op_d = bus.op_code;
          if (bus.op_code == OP_MUL) state_d[S_LOADQ] = 1'b1;
          else                       state_d[S_LOADA] = 1'b1;
        end else begin
          state_d[S_IDLE] = 1'b1;
        end
      end
      state_q[S_LOADA]: begin
        if (is_div) state_d[S_LOADQ] = 1'b1;
        else        state_d[S_LOADM] = 1'b1;
      end
      state_q[S_LOADQ]: state_d[S_LOADM] = 1'b1;
      state_q[S_LOADM]: begin
        cnt_r_d = '0;
        cnt_s_d = '0;
        lz_d    = '0;
        if (is_mul) begin
          if (booth_add) state_d[S_ADD]     = 1'b1;
          else           state_d[S_RSHIFT2] = 1'b1;
        end else if (is_div) begin
          if (div_zero)               state_d[S_DIVZ]   = 1'b1;
          else if (!bus.sgn_bit_of_M) state_d[S_NORM]   = 1'b1;
          else                        state_d[S_LSHIFT] = 1'b1;
        end else begin
          state_d[S_ADD] = 1'b1;
        end
      end
      state_q[S_ADD]: begin
        if (is_mul) begin
          state_d[S_RSHIFT2] = 1'b1;
        end else if (is_div) begin
          if (cnt_s_q != S_DONE) state_d[S_LSHIFT] = 1'b1;
          else if (a_neg)        state_d[S_CORR_A] = 1'b1;
          else                   state_d[S_FIX_Q]  = 1'b1;
        end else begin
          state_d[S_PUSHA] = 1'b1;
        end
      end
      state_q[S_RSHIFT2]: begin
        cnt_r_d = cnt_r_q + ONE;
        if (cnt_r_q == R_LAST) state_d[S_PUSHA]   = 1'b1;
        else if (booth_add)    state_d[S_ADD]     = 1'b1;
        else                   state_d[S_RSHIFT2] = 1'b1;
      end
      state_q[S_PUSHA]: begin
        if (is_mul) begin
          state_d[S_PUSHQ] = 1'b1;
        end else begin
          state_d[S_IDLE] = 1'b1;
          done_d          = 1'b1;
        end
      end
      state_q[S_PUSHQ]: begin
        if (is_mul) begin
          state_d[S_IDLE] = 1'b1;
          done_d          = 1'b1;
        end else begin
          state_d[S_PUSHA] = 1'b1;
        end
      end
      state_q[S_NORM]: begin
        // lz stops at WIDTH-1 so an unnormalisable divisor still terminates
        lz_d = lz_q + ONE;
        if (bus.sgn_bit_of_M || (lz_q == LZ_LAST)) state_d[S_LSHIFT] = 1'b1;
        else                                       state_d[S_NORM]   = 1'b1;
      end
      state_q[S_LSHIFT]: begin
        cnt_s_d = cnt_s_q + ONE;
        digit_d = {a_flag, a_neg};
        if (a_flag)                 state_d[S_ADD]    = 1'b1;
        else if (cnt_s_q != S_LAST) state_d[S_LSHIFT] = 1'b1;
        else if (a_neg)             state_d[S_CORR_A] = 1'b1;
        else                        state_d[S_FIX_Q]  = 1'b1;
      end
      state_q[S_CORR_A]:  state_d[S_CORR_QP] = 1'b1;
      state_q[S_CORR_QP]: state_d[S_FIX_Q]   = 1'b1;
      state_q[S_FIX_Q]: begin
        if (lz_q != '0) state_d[S_DENORM] = 1'b1;
        else            state_d[S_PUSHQ]  = 1'b1;
      end
      state_q[S_DENORM]: begin
        lz_d = lz_q - ONE;
        if (lz_q == ONE) state_d[S_PUSHQ]  = 1'b1;
        else             state_d[S_DENORM] = 1'b1;
      end
      state_q[S_DIVZ]: begin
        state_d[S_IDLE] = 1'b1;
        done_d          = 1'b1;
      end
      default: state_d[S_IDLE] = 1'b1;
    endcase
  end

  always_comb begin
    bus.load_a        = state_q[S_LOADA];
    bus.load_q        = state_q[S_LOADQ];
    bus.load_m        = state_q[S_LOADM];
    bus.init_a0       = state_q[S_LOADQ] & is_mul;
    bus.init_qq       = state_q[S_LOADM] & is_mul;
    bus.load_a_adder  = state_q[S_CORR_A];
    bus.load_qp_adder = state_q[S_CORR_QP];
    bus.load_q_adder  = state_q[S_FIX_Q];
    bus.sel_am        = state_q[S_CORR_A];
    bus.sel_2m        = 1'b0;
    bus.sel_qp1       = state_q[S_CORR_QP];
    bus.sel_qqp       = state_q[S_FIX_Q];
    bus.sum_or_dif    = state_q[S_FIX_Q];
    bus.rshift2       = state_q[S_RSHIFT2];
    bus.lshift        = state_q[S_LSHIFT];
    bus.norm_shift    = state_q[S_NORM];
    bus.denorm_shift  = state_q[S_DENORM];
    bus.q_wr          = state_q[S_LSHIFT];
    bus.q_val         = state_q[S_LSHIFT] & a_flag & ~a_neg;
    bus.qp_val        = state_q[S_LSHIFT] & a_flag & a_neg;
    bus.push_a        = state_q[S_PUSHA];
    bus.push_q        = state_q[S_PUSHQ];
    bus.busy          = ~state_q[S_IDLE];
    bus.div_by_zero   = state_q[S_DIVZ];
    bus.END           = state_q[S_IDLE] & done_q;
    if (state_q[S_ADD]) begin
      bus.sel_am       = 1'b1;
      bus.load_a_adder = is_div ? digit_q[1] : 1'b1;
      if (is_mul) begin
        bus.sel_2m     = (bus.bits_of_Q == 3'b011) || (bus.bits_of_Q == 3'b100);
        bus.sum_or_dif = bus.bits_of_Q[2];
      end else if (is_div) begin
        bus.sum_or_dif = ~digit_q[0];
      end else begin
        bus.sum_or_dif = op_q[0];
      end
    end
  end
endmodule
